cix_iter: RTL and testbench

- Iterative, handshaked bit counter for wide words.
- Computes CLZ, CTZ, population count or CLO on a 2**ORDER-bit word by scanning 2**STEP-bit chunks, one chunk per clock.
- Trades latency for area relative to the single-cycle combinational counters.
- Sits between an issue stage and ALU writeback as a multi-cycle functional unit.

---
 rtl/cix_iter.sv | 128 ++++++++++++
 tb/tb_cix_iter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cix_iter.sv
// cix_iter: iterative CLZ/CTZ/PCNT/CLO unit that scans one 2**STEP-bit chunk per clock.
// Optional build macro CIX_ITER_EARLY_EN ends the scan on the first nonzero chunk.
module cix_iter #(
  parameter int ORDER = 5,
  parameter int STEP  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [2**ORDER-1:0] in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ORDER:0]      out_count,
  output logic                out_zero
);

  localparam int W  = 2**ORDER;
  localparam int C  = 2**STEP;
  localparam int N  = W / C;
  localparam int IW = (ORDER > STEP) ? (ORDER - STEP) : 1;
  localparam logic [ORDER:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   operand;
  logic [ORDER:0] count, add;
  logic [IW-1:0]  idx;
  logic           from_low, pcnt, stopped;
  logic [C-1:0]   chunk;
  logic           last, hit;

  function automatic logic [ORDER:0] popc(input logic [C-1:0] v);
    logic [ORDER:0] r;
    r = '0;
    for (int i = 0; i < C; i++) r = r + {{ORDER{1'b0}}, v[i]};
    return r;
  endfunction

  function automatic logic [ORDER:0] lzc(input logic [C-1:0] v);
    logic [ORDER:0] r;
    logic           found;
    r = '0;
    found = 1'b0;
    for (int i = C - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      r = r + ONE;
      end
    end
    return r;
  endfunction

  function automatic logic [ORDER:0] tzc(input logic [C-1:0] v);
    logic [ORDER:0] r;
    logic           found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      r = r + ONE;
      end
    end
    return r;
  endfunction

  // CLO is folded into CLZ at accept time, so the scan only knows two directions.
  always_comb begin
    chunk     = from_low ? operand[C-1:0] : operand[W-1 -: C];
    last      = (idx == IW'(N - 1));
    hit       = !pcnt && !stopped && (chunk != '0);
    add       = '0;
    state_nxt = state;
    if (pcnt)          add = popc(chunk);
    else if (!stopped) add = from_low ? tzc(chunk) : lzc(chunk);
    case (state)
      IDLE: if (in_valid) state_nxt = SCAN;
      SCAN: begin
        if (last) state_nxt = DONE;
`ifdef CIX_ITER_EARLY_EN
        if (hit) state_nxt = DONE;
`endif
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      operand  <= '0;
      count    <= '0;
      idx      <= '0;
      from_low <= 1'b0;
      pcnt     <= 1'b0;
      stopped  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          operand  <= (in_mode == 2'b11) ? ~in_word : in_word;
          from_low <= (in_mode == 2'b01);
          pcnt     <= (in_mode == 2'b10);
          count    <= '0;
          idx      <= '0;
          stopped  <= 1'b0;
        end
        SCAN: begin
          count   <= count + add;
          idx     <= idx + IW'(1);
          operand <= from_low ? (operand >> C) : (operand << C);
          if (hit) stopped <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_count = count;
  assign out_zero  = (count == '0);

endmodule

// File: tb/tb_cix_iter.sv
// Directed and sweep bench for cix_iter; honours CIX_ITER_EARLY_EN for expected latencies.
module tb_cix_iter;

`ifdef CIX_ITER_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [1:0]  in_mode;
  logic [31:0] in_word;
  logic [5:0]  out_count;

  logic       s_in_valid[2], s_in_ready[2], s_out_valid[2], s_out_ready[2], s_out_zero[2];
  logic [1:0] s_in_mode[2];
  logic [7:0] s_in_word[2];
  logic [3:0] s_out_count[2];

  int checks = 0;
  int passed = 0;

  cix_iter #(.ORDER(5), .STEP(3)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_zero(out_zero)
  );

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    cix_iter #(.ORDER(3), .STEP(g == 0 ? 1 : 0)) u_small (
      .clock(clock), .reset(reset),
      .in_valid(s_in_valid[g]), .in_ready(s_in_ready[g]), .in_mode(s_in_mode[g]),
      .in_word(s_in_word[g]), .out_valid(s_out_valid[g]), .out_ready(s_out_ready[g]),
      .out_count(s_out_count[g]), .out_zero(s_out_zero[g])
    );
  end

  function automatic int ref_count(input int m, input logic [31:0] v, input int w);
    logic [31:0] x;
    int r;
    x = (m == 3) ? ~v : v;
    r = 0;
    if (m == 2) begin
      for (int i = 0; i < w; i++) r += int'(x[i]);
    end else if (m == 1) begin
      for (int i = 0; i < w && !x[i]; i++) r++;
    end else begin
      for (int i = w - 1; i >= 0 && !x[i]; i--) r++;
    end
    return r;
  endfunction

  function automatic int ref_lat(input int m, input int cnt, input int c, input int n);
    int l;
    if (!EARLY || m == 2) return n;
    l = cnt / c + 1;
    return (l > n) ? n : l;
  endfunction

  task automatic start_op(input logic [1:0] m, input logic [31:0] w,
                          output logic [5:0] cnt, output logic z, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_mode  = m;
    in_word  = w;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_mode  = ~m;
    in_word  = ~w;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    cnt = out_count;
    z   = out_zero;
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_count !== 6'd0) $display("[TB] FAIL reset_out_count: got %0d want 0", out_count); else passed++;
    checks++; if (out_zero !== 1'b1) $display("[TB] FAIL reset_out_zero: got %b want 1", out_zero); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_count_modes;
    logic [1:0]  vm[11] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] vw[11] = '{32'h00010000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hF0FFFFFF,
                            32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000100, 32'hFFFFFFFF,
                            32'h12345678};
    int          vc[11] = '{15, 32, 32, 0, 4, 31, 0, 32, 8, 32, 13};
    logic        vz[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int          vl[11] = '{2, 4, 4, 4, 1, 4, 1, 4, 2, 4, 4};
    logic [5:0]  cnt;
    logic        z;
    int          lat, want_lat;
    for (int i = 0; i < 11; i++) begin
      start_op(vm[i], vw[i], cnt, z, lat);
      want_lat = EARLY ? vl[i] : 4;
      checks++; if (cnt !== 6'(vc[i])) $display("[TB] FAIL count_v%0d: got %0d want %0d", i, cnt, vc[i]); else passed++;
      checks++; if (z !== vz[i]) $display("[TB] FAIL zero_v%0d: got %b want %b", i, z, vz[i]); else passed++;
      checks++; if (lat != want_lat) $display("[TB] FAIL latency_v%0d: got %0d want %0d", i, lat, want_lat); else passed++;
      finish_op();
    end
  endtask

  task automatic test_backpressure;
    logic [5:0] cnt;
    logic       z;
    int         lat;
    start_op(2'b00, 32'h00010000, cnt, z, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 6'd15 || out_zero !== 1'b0)
        $display("[TB] FAIL hold_c%0d: got valid=%b ready=%b count=%0d zero=%b want 1 0 15 0",
                 i, out_valid, in_ready, out_count, out_zero);
      else passed++;
    end
    finish_op();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL release_out_valid: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_abort;
    logic [5:0] cnt;
    logic       z, seen;
    int         lat;
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_word  = 32'h00000000;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL abort_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL abort_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_count !== 6'd0) $display("[TB] FAIL abort_out_count: got %0d want 0", out_count); else passed++;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL abort_no_result: got valid=%b want 0", seen); else passed++;
    start_op(2'b00, 32'h00000001, cnt, z, lat);
    checks++; if (cnt !== 6'd31) $display("[TB] FAIL after_abort_count: got %0d want 31", cnt); else passed++;
    checks++; if (lat != 4) $display("[TB] FAIL after_abort_latency: got %0d want 4", lat); else passed++;
    finish_op();
  endtask

  task automatic test_back_to_back;
    int   t[$];
    logic prev;
    prev      = 1'b0;
    in_mode   = 2'b10;
    in_word   = 32'h000000FF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clock); #1;
      if (prev) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
          $display("[TB] FAIL b2b_no_accept_c%0d: got ready=%b valid=%b want 1 0", cyc, in_ready, out_valid);
        else passed++;
      end
      if (out_valid) begin
        t.push_back(cyc);
        checks++; if (out_count !== 6'd8) $display("[TB] FAIL b2b_count_c%0d: got %0d want 8", cyc, out_count); else passed++;
      end
      prev = out_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (t.size() < 3) $display("[TB] FAIL b2b_results: got %0d want >=3", t.size());
    else begin
      passed++;
      checks++; if (t[1] - t[0] != 6) $display("[TB] FAIL b2b_period0: got %0d want 6", t[1] - t[0]); else passed++;
      checks++; if (t[2] - t[1] != 6) $display("[TB] FAIL b2b_period1: got %0d want 6", t[2] - t[1]); else passed++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_sweep(input int k);
    int n, c, exp_cnt, exp_lat, lat, guard, hold;
    n = (k == 0) ? 4 : 8;
    c = (k == 0) ? 2 : 1;
    for (int w = 0; w < 256; w++) begin
      for (int m = 0; m < 4; m++) begin
        guard = 0;
        while (!s_in_ready[k] && guard < 50) begin
          @(posedge clock); #1;
          guard++;
        end
        s_in_valid[k] = 1'b1;
        s_in_mode[k]  = 2'(m);
        s_in_word[k]  = 8'(w);
        @(posedge clock); #1;
        s_in_valid[k] = 1'b0;
        s_in_word[k]  = ~8'(w);
        lat = 0;
        while (!s_out_valid[k] && lat < 50) begin
          @(posedge clock); #1;
          lat++;
        end
        exp_cnt = ref_count(m, {24'd0, 8'(w)}, 8);
        exp_lat = ref_lat(m, exp_cnt, c, n);
        checks++; if (lat != exp_lat) $display("[TB] FAIL sweep%0d_lat w=%0d m=%0d: got %0d want %0d", k, w, m, lat, exp_lat); else passed++;
        hold = $urandom_range(0, 2);
        repeat (hold) @(posedge clock);
        #1;
        checks++;
        if (s_out_valid[k] !== 1'b1 || s_out_count[k] !== 4'(exp_cnt))
          $display("[TB] FAIL sweep%0d_count w=%0d m=%0d: got valid=%b count=%0d want 1 %0d",
                   k, w, m, s_out_valid[k], s_out_count[k], exp_cnt);
        else passed++;
        checks++; if (s_out_zero[k] !== (exp_cnt == 0)) $display("[TB] FAIL sweep%0d_zero w=%0d m=%0d: got %b want %b", k, w, m, s_out_zero[k], exp_cnt == 0); else passed++;
        s_out_ready[k] = 1'b1;
        @(posedge clock); #1;
        s_out_ready[k] = 1'b0;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_word   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_in_valid[i]  = 1'b0;
      s_in_mode[i]   = 2'b00;
      s_in_word[i]   = '0;
      s_out_ready[i] = 1'b0;
    end
    test_reset();
    test_count_modes();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_sweep(0);
    test_sweep(1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
